comp_serial: RTL and testbench
==============================

COMP_SERIAL -- requirements
Module: comp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; must be even and >= 4.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to compare a and b, sampled on clock.
REQ-005 SHALL have port a  input  WIDTH  first operand, sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand, sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress, i.e. in state RUN or DONE.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 SHALL have port eq  output  1  registered result, a == b.
REQ-010 SHALL have port gt  output  1  registered result, a > b.
REQ-011 SHALL have port lt  output  1  registered result, a < b.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE: on acceptance, latch a and b, set running eq-state = 1 and gt-state = 0, set digit index = WIDTH/2-1, and go to RUN.
REQ-014 SHALL ignore start while in RUN or DONE, with no effect on latched operands or results.
REQ-015 SHALL, in each RUN cycle, compare one 2-bit digit {op[2i+1], op[2i]} of each operand, MSB digit first, using the cascade rule: gt_next = gt | (eq & digit_a > digit_b); eq_next = eq & (digit_a == digit_b).
REQ-016 SHALL leave RUN for DONE early, in the same cycle in which a digit mismatch is detected.
REQ-017 SHALL otherwise leave RUN for DONE after processing digit index 0, and decrement the index each RUN cycle in between.
REQ-018 SHALL, on entry to DONE, update registered eq, gt, and lt, where lt = ~eq & ~gt; exactly one of eq, gt, lt is high after the first done.
REQ-019 SHALL assert done for exactly one cycle while in DONE, then return to IDLE.
REQ-020 SHALL hold eq, gt, and lt stable from done until the next done.
REQ-021 SHALL have latency, for start accepted at edge t, of: mismatch at digit k (counted from MSB, k=0) gives done high in cycle t+2+k; fully equal operands give done high in cycle t+1+WIDTH/2 (t+17 for WIDTH=32).
REQ-022 SHALL accept a start asserted in the cycle done is high at the following edge only if the FSM is then in IDLE; back-to-back throughput is one comparison per latency+1 cycles.

Reset
REQ-023 SHALL, while reset_n is low, force the state to IDLE and busy, done, eq, gt, and lt to 0, regardless of clock.
REQ-024 SHALL abandon any comparison in progress when reset is asserted mid-RUN; no done is issued for it.
REQ-025 SHALL clear the latched operands and digit index to 0 on reset.

Configuration
REQ-026 SHALL, when macro COMP_SERIAL_SIGNED_EN is defined, treat operands as two's complement by inverting bit WIDTH-1 of both latched operands before comparison, which affects only the MSB digit.
REQ-027 SHALL, when COMP_SERIAL_SIGNED_EN is undefined, perform an unsigned comparison with no additional logic.

Verification
REQ-028 SHALL cover: reset_n low mid-RUN with a=32'h0000_0001, b=32'h0000_0000 -> busy=0, done never pulses, and eq=gt=lt=0.
REQ-029 SHALL cover: unsigned a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, start at edge t -> done only in cycle t+17, with eq=1, gt=0, lt=0.
REQ-030 SHALL cover: a=32'h8000_0000, b=32'h4000_0000 -> done in cycle t+2 (early exit); gt=1 when unsigned, lt=1 with COMP_SERIAL_SIGNED_EN.
REQ-031 SHALL cover: a=32'h0000_0002, b=32'h0000_0003 -> done in cycle t+17, lt=1; changing a and b while busy does not alter the result.
REQ-032 SHALL cover: start held high continuously with alternating operand pairs -> each done is followed by a one-cycle IDLE before the next acceptance; start during busy is ignored.
REQ-033 SHALL cover: signed build with a=32'hFFFF_FFFF (-1) and b=32'h0000_0001 -> lt=1, and done in cycle t+2.

Source files
------------

// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - serial magnitude comparator, one 2-bit digit per cycle
//
// Compares two WIDTH-bit operands MSB digit first, leaving early on the first
// differing digit. Results are registered and held until the next done.
//
// Build option: define COMP_SERIAL_SIGNED_EN for a two's complement compare
// (sign bit of both latched operands inverted); default is unsigned.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   compare request, accepted only in IDLE
//   a, b     in   operands, latched when start is accepted
//   busy     out  comparison in progress (RUN or DONE)
//   done     out  one-cycle pulse, eq/gt/lt valid
//   eq/gt/lt out  registered result; exactly one high after the first done

module comp_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int DIGITS = WIDTH / 2;
   localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic             r_eq_s;
   logic             r_gt_s;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;
   logic [WIDTH-1:0] w_a_in;
   logic [WIDTH-1:0] w_b_in;
   logic [1:0]       w_dig_a;
   logic [1:0]       w_dig_b;
   logic             w_eq_nxt;
   logic             w_gt_nxt;
   logic             w_accept;

`ifdef COMP_SERIAL_SIGNED_EN
   // Flipping the sign bit maps two's complement order onto unsigned order,
   // so the digit cascade itself is unchanged.
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_a_in = a ^ SIGN_MASK;
   assign w_b_in = b ^ SIGN_MASK;
`else
   assign w_a_in = a;
   assign w_b_in = b;
`endif

   assign w_dig_a  = 2'(r_a >> {r_idx, 1'b0});
   assign w_dig_b  = 2'(r_b >> {r_idx, 1'b0});
   assign w_eq_nxt = r_eq_s & (w_dig_a == w_dig_b);
   assign w_gt_nxt = r_gt_s | (r_eq_s & (w_dig_a > w_dig_b));
   assign w_accept = (r_state == IDLE) & start;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = RUN;
         // A mismatch settles the result, so there is no point scanning on.
         RUN:  if (!w_eq_nxt || (r_idx == '0)) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_idx  <= '0;
         r_eq_s <= 1'b0;
         r_gt_s <= 1'b0;
         r_eq   <= 1'b0;
         r_gt   <= 1'b0;
         r_lt   <= 1'b0;
      end else if (w_accept) begin
         r_a    <= w_a_in;
         r_b    <= w_b_in;
         r_eq_s <= 1'b1;
         r_gt_s <= 1'b0;
         r_idx  <= LAST_IDX;
      end else if (r_state == RUN) begin
         r_eq_s <= w_eq_nxt;
         r_gt_s <= w_gt_nxt;
         if (w_state_nxt == RUN) begin
            r_idx <= r_idx - IW'(1);
         end else begin
            r_eq <= w_eq_nxt;
            r_gt <= w_gt_nxt;
            r_lt <= ~w_eq_nxt & ~w_gt_nxt;
         end
      end
   end

   assign busy = (r_state == RUN) | (r_state == DONE);
   assign done = (r_state == DONE);
   assign eq   = r_eq;
   assign gt   = r_gt;
   assign lt   = r_lt;

endmodule

// File: tb/tb_comp_serial.sv
// tb/tb_comp_serial.sv - directed self-checking bench for comp_serial

module tb_comp_serial;

`ifdef COMP_SERIAL_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif

   // {eq, gt, lt} encodings
   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_GT = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic        eq;
   logic        gt;
   logic        lt;

   int checks = 0;
   int errors = 0;

   comp_serial #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .eq      (eq),
      .gt      (gt),
      .lt      (lt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at #1 after an edge with the DUT idle. exp_cyc is N in "done in
   // cycle t+N" where t is the accepting edge.
   task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input int exp_cyc, input logic [2:0] exp_res);
      int seen;
      seen  = 0;
      a     = va;
      b     = vb;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      a     = ~va;
      b     = vb ^ 32'h5A5A_0F0F;
      for (int j = 0; j < 40 && seen == 0; j++) begin
         if (done) seen = j + 1;
         else begin
            @(posedge clock); #1;
         end
      end
      chk({tag, "_latency"}, seen, exp_cyc);
      chk({tag, "_result"}, {29'd0, eq, gt, lt}, {29'd0, exp_res});
      @(posedge clock); #1;
      chk({tag, "_after_busy_done"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_hold"}, {29'd0, eq, gt, lt}, {29'd0, exp_res});
   endtask

   initial begin
      logic [31:0] pa [2];
      logic [31:0] pb [2];
      logic [2:0]  pexp [2];
      int          pulses;
      int          nd;

      // reset state
      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_res", {29'd0, eq, gt, lt}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);

      run_cmp("all_ones_equal", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, R_EQ);
      run_cmp("msb_digit", 32'h8000_0000, 32'h4000_0000, 2, SIGNED ? R_LT : R_GT);
      run_cmp("lsb_digit_lt", 32'h0000_0002, 32'h0000_0003, 17, R_LT);
      run_cmp("neg1_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 2, SIGNED ? R_LT : R_GT);
      run_cmp("digit3_gt", 32'h1234_5678, 32'h1234_5600, 14, R_GT);
      run_cmp("zero_equal", 32'h0000_0000, 32'h0000_0000, 17, R_EQ);

      // reset during RUN abandons the comparison
      a = 32'h0000_0001;
      b = 32'h0000_0000;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      pulses = 0;
      repeat (5) begin
         @(posedge clock); #1;
         if (done) pulses++;
      end
      chk("midrun_busy_before", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
      chk("midrun_rst_done", {31'd0, done}, 32'd0);
      chk("midrun_rst_res", {29'd0, eq, gt, lt}, 32'd0);
      @(posedge clock); #2;
      reset_n = 1'b1;
      repeat (20) begin
         @(posedge clock); #1;
         if (done || busy) pulses++;
      end
      chk("midrun_no_done", pulses, 32'd0);
      chk("midrun_res_after", {29'd0, eq, gt, lt}, 32'd0);

      // start held high: accept, RUN, DONE, IDLE, accept ... period 3
      pa[0] = 32'h8000_0000; pb[0] = 32'h4000_0000; pexp[0] = SIGNED ? R_LT : R_GT;
      pa[1] = 32'h4000_0000; pb[1] = 32'h8000_0000; pexp[1] = SIGNED ? R_GT : R_LT;
      nd = 0;
      a = pa[0];
      b = pb[0];
      start = 1'b1;
      @(posedge clock); #1;
      a = 32'h1234_5678;
      b = 32'h1234_5678;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clock); #1;
         chk($sformatf("b2b_busy_e%0d", e), {31'd0, busy}, {31'd0, (e % 3) != 2});
         chk($sformatf("b2b_done_e%0d", e), {31'd0, done}, {31'd0, (e % 3) == 1});
         if ((e % 3) == 1) begin
            chk($sformatf("b2b_res_%0d", nd), {29'd0, eq, gt, lt}, {29'd0, pexp[nd % 2]});
            nd++;
            a = pa[nd % 2];
            b = pb[nd % 2];
         end else if ((e % 3) == 0) begin
            a = 32'h1234_5678;
            b = 32'h1234_5678;
         end
      end
      start = 1'b0;
      chk("b2b_count", nd, 32'd4);
      repeat (4) @(posedge clock);
      #1;
      chk("final_idle", {30'd0, busy, done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
